hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS pipeline. It drives the IF/ID register's write-enable and flush (NOP insert), the PC write-enable and the ID/EX bubble insert. It resolves four hazards:
- load-use data hazards
- taken-branch flushes
- data-memory wait freezes
- HI/LO use while the multi-cycle mult/div unit is busy

It sits beside IF_ID and the hazard/forwarding logic, observing the ID-stage instruction and EX-stage status.

---
 rtl/hazard_stall_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: resolves load-use, taken-branch, dmem-wait and
// HI/LO-vs-mult/div hazards into PC / IF-ID / ID-EX enables, flush and bubble.
module hazard_stall_ctrl #(
    parameter int          MD_LATENCY  = 4,
    parameter logic [31:0] NOP_IR      = 32'h80000000,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [31:0]            id_ir,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_rt,
    input  logic                   branch_taken,
    input  logic                   dmem_wait,
    input  logic                   md_start,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   md_busy,
    output logic [1:0]             ctrl_state,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LU     = 2'd1,
        ST_MD     = 2'd2,
        ST_FREEZE = 2'd3
    } state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] md_cnt;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       is_nop;
    logic       uses_rt;
    logic       hilo_use;
    logic       load_use;
    logic       md_hazard;
    logic       md_busy_int;

    // ID-stage decode and hazard detection
    assign op       = id_ir[31:26];
    assign rs       = id_ir[25:21];
    assign rt       = id_ir[20:16];
    assign funct    = id_ir[5:0];
    assign is_nop   = (id_ir == NOP_IR);
    assign uses_rt  = (op == 6'd0) | (op == 6'd4) | (op == 6'd5) | (op[5:3] == 3'b101);
    assign hilo_use = (op == 6'd0) &
                      ((funct == 6'h10) | (funct == 6'h12) | (funct == 6'h18) |
                       (funct == 6'h19) | (funct == 6'h1A) | (funct == 6'h1B));

    assign md_busy_int = (md_cnt != 4'd0);
    assign load_use    = !is_nop & ex_mem_read & (ex_rt != 5'd0) &
                         ((ex_rt == rs) | (uses_rt & (ex_rt == rt)));
    assign md_hazard   = !is_nop & md_busy_int & hilo_use;

    // Priority resolution; reset forces a safe flushed, non-advancing pipe
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_d      = ST_RUN;
        if (!reset_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (dmem_wait) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            state_d      = ST_FREEZE;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use || md_hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = load_use ? ST_LU : ST_MD;
        end
    end

    assign md_busy    = reset_n & md_busy_int;
    assign ctrl_state = state_q;

    // Registered decision, mult/div countdown and stall statistics
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            md_cnt       <= 4'd0;
            stall_cycles <= '0;
        end else begin
            state_q <= state_d;
            if (!dmem_wait) begin
                if (md_start)
                    md_cnt <= MD_LOAD;
                else if (md_busy_int)
                    md_cnt <= md_cnt - 4'd1;
            end
            if (state_d != ST_RUN && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: per-cycle comparison against a rule-level model
// plus directed scenarios with hand-computed expectations.
module tb_hazard_stall_ctrl;

    localparam int          MD_LAT  = 4;
    localparam logic [31:0] NOP     = 32'h80000000;
    localparam int          SCW     = 16;
    localparam int          SAT_MAX = (1 << SCW) - 1;

    localparam logic [31:0] ADD_10_8_9 = 32'h01095020;
    localparam logic [31:0] LW_9_0_8   = 32'h8D090000;
    localparam logic [31:0] MFLO_2     = 32'h00001012;

    // decision codes used by the model
    localparam int D_RUN = 0, D_LU = 1, D_MD = 2, D_FRZ = 3, D_FLUSH = 4;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [31:0]    id_ir;
    logic           ex_mem_read;
    logic [4:0]     ex_rt;
    logic           branch_taken;
    logic           dmem_wait;
    logic           md_start;
    logic           pc_write;
    logic           if_id_write;
    logic           if_id_flush;
    logic           id_ex_bubble;
    logic           md_busy;
    logic [1:0]     ctrl_state;
    logic [SCW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    hazard_stall_ctrl #(
        .MD_LATENCY (MD_LAT),
        .NOP_IR     (NOP),
        .STALL_CNT_W(SCW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .id_ir       (id_ir),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .branch_taken(branch_taken),
        .dmem_wait   (dmem_wait),
        .md_start    (md_start),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .if_id_flush (if_id_flush),
        .id_ex_bubble(id_ex_bubble),
        .md_busy     (md_busy),
        .ctrl_state  (ctrl_state),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int decide(input logic [31:0] ir, input logic emr, input logic [4:0] ert,
                                  input logic bt, input logic dw, input bit busy);
        int  op, fn, src_s, src_t;
        bit  reads_t, hilo, lu;
        op    = int'(ir[31:26]);
        fn    = int'(ir[5:0]);
        src_s = int'(ir[25:21]);
        src_t = int'(ir[20:16]);
        reads_t = (op == 0) || (op == 4) || (op == 5) || (op >= 40 && op <= 47);
        hilo    = (op == 0) && (fn inside {16, 18, 24, 25, 26, 27});
        lu      = emr && ert != 0 && (int'(ert) == src_s || (reads_t && int'(ert) == src_t));
        if (ir == NOP) begin
            lu   = 0;
            hilo = 0;
        end
        if (dw)               return D_FRZ;
        if (bt)               return D_FLUSH;
        if (lu)               return D_LU;
        if (hilo && busy)     return D_MD;
        return D_RUN;
    endfunction

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    function automatic logic [3:0] enables_of(input int d);
        case (d)
            D_FRZ:       return 4'b0000;
            D_FLUSH:     return 4'b1111;
            D_LU, D_MD:  return 4'b0001;
            default:     return 4'b1100;
        endcase
    endfunction

    int m_md, m_state, m_stall, m_dec;

    always_comb m_dec = decide(id_ir, ex_mem_read, ex_rt, branch_taken, dmem_wait, m_md > 0);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_md    <= 0;
            m_state <= 0;
            m_stall <= 0;
        end else begin
            m_state <= (m_dec == D_FLUSH) ? D_RUN : m_dec;
            if (m_dec != D_RUN && m_dec != D_FLUSH && m_stall < SAT_MAX)
                m_stall <= m_stall + 1;
            if (!dmem_wait) begin
                if (md_start)      m_md <= MD_LAT;
                else if (m_md > 0) m_md <= m_md - 1;
            end
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clock) begin
        logic [3:0] e;
        e = reset_n ? enables_of(m_dec) : 4'b0011;
        chk("cmp_enables", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, {28'd0, e});
        chk("cmp_md_busy", {31'd0, md_busy}, (reset_n && m_md > 0) ? 32'd1 : 32'd0);
        chk("cmp_ctrl_state", {30'd0, ctrl_state}, m_state);
        chk("cmp_stall_cycles", {16'd0, stall_cycles}, m_stall);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        id_ir        = NOP;
        ex_mem_read  = 1'b0;
        ex_rt        = 5'd0;
        branch_taken = 1'b0;
        dmem_wait    = 1'b0;
        md_start     = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        #2 reset_n = 1'b0;
        idle_inputs();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        reset_n = 1'b1;
        #1;
        chk("release_pc_write", {31'd0, pc_write}, 32'd1);
        chk("release_if_id_write", {31'd0, if_id_write}, 32'd1);

        // load-use: add $10,$8,$9 behind a load to $8
        id_ir = ADD_10_8_9; ex_mem_read = 1'b1; ex_rt = 5'd8;
        #1;
        chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
        chk("lu_if_id_write", {31'd0, if_id_write}, 32'd0);
        chk("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
        tick();
        ex_mem_read = 1'b0;
        #1;
        chk("lu_state", {30'd0, ctrl_state}, 32'd1);
        chk("lu_stall_cycles", {16'd0, stall_cycles}, 32'd1);
        chk("lu_one_cycle", {31'd0, pc_write}, 32'd1);

        // asynchronous reset in mid-cycle while state is LU_STALL
        #2 reset_n = 1'b0;
        #1;
        chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
        chk("rst_flush", {31'd0, if_id_flush}, 32'd1);
        chk("rst_bubble", {31'd0, id_ex_bubble}, 32'd1);
        chk("rst_state", {30'd0, ctrl_state}, 32'd0);
        chk("rst_stall_cycles", {16'd0, stall_cycles}, 32'd0);
        idle_inputs();
        tick();
        reset_n = 1'b1;
        #1;
        chk("rst_rel_pc_write", {31'd0, pc_write}, 32'd1);
        chk("rst_rel_if_id_write", {31'd0, if_id_write}, 32'd1);

        // ex_rt = 0 never stalls
        id_ir = ADD_10_8_9; ex_mem_read = 1'b1; ex_rt = 5'd0;
        #1;
        chk("rt0_pc_write", {31'd0, pc_write}, 32'd1);
        chk("rt0_bubble", {31'd0, id_ex_bubble}, 32'd0);
        tick();
        chk("rt0_state", {30'd0, ctrl_state}, 32'd0);

        // lw $9,0($8) does not read rt
        id_ir = LW_9_0_8; ex_rt = 5'd9;
        #1;
        chk("lw_rt_pc_write", {31'd0, pc_write}, 32'd1);
        tick();
        chk("lw_rt_state", {30'd0, ctrl_state}, 32'd0);

        // branch flush overrides load-use
        id_ir = ADD_10_8_9; ex_rt = 5'd8; branch_taken = 1'b1;
        #1;
        chk("br_pc_write", {31'd0, pc_write}, 32'd1);
        chk("br_flush", {31'd0, if_id_flush}, 32'd1);
        chk("br_bubble", {31'd0, id_ex_bubble}, 32'd1);
        tick();
        branch_taken = 1'b0; ex_mem_read = 1'b0;
        chk("br_state", {30'd0, ctrl_state}, 32'd0);
        chk("br_stall_cycles", {16'd0, stall_cycles}, 32'd0);

        // freeze over a load-use, then the load-use stall still applies
        do_reset();
        id_ir = ADD_10_8_9; ex_mem_read = 1'b1; ex_rt = 5'd8; dmem_wait = 1'b1;
        #1;
        chk("frz_enables", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, 32'd0);
        repeat (3) tick();
        chk("frz_state", {30'd0, ctrl_state}, 32'd3);
        chk("frz_stall_cycles", {16'd0, stall_cycles}, 32'd3);
        dmem_wait = 1'b0;
        #1;
        chk("frz_then_lu_pc", {31'd0, pc_write}, 32'd0);
        chk("frz_then_lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
        tick();
        ex_mem_read = 1'b0;
        chk("frz_then_lu_state", {30'd0, ctrl_state}, 32'd1);
        chk("frz_then_lu_cnt", {16'd0, stall_cycles}, 32'd4);

        // mult/div busy with mflo waiting, two frozen cycles in the middle
        do_reset();
        md_start = 1'b1;
        tick();
        md_start = 1'b0; id_ir = MFLO_2;
        #1;
        chk("md_busy_set", {31'd0, md_busy}, 32'd1);
        chk("md_stall_pc", {31'd0, pc_write}, 32'd0);
        repeat (2) tick();
        dmem_wait = 1'b1;
        repeat (2) tick();
        dmem_wait = 1'b0;
        tick();
        chk("md_still_busy", {31'd0, md_busy}, 32'd1);
        chk("md_still_stall", {31'd0, pc_write}, 32'd0);
        tick();
        chk("md_done_busy", {31'd0, md_busy}, 32'd0);
        chk("md_done_pc", {31'd0, pc_write}, 32'd1);
        chk("md_total_stall", {16'd0, stall_cycles}, 32'd6);

        // saturation of the stall counter
        do_reset();
        dmem_wait = 1'b1;
        repeat ((1 << SCW) + 5) tick();
        chk("sat_stall_cycles", {16'd0, stall_cycles}, 32'h0000FFFF);
        chk("sat_state", {30'd0, ctrl_state}, 32'd3);
        dmem_wait = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
